// File: rtl/vector_op_arbiter_if.sv
// Request/result bundle between two requesters, the shared vector logic unit and its consumer.
// The slave side is the arbiter; the master side drives requests and accepts results.
interface vector_op_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic               req0_valid;
    logic               req0_ready;
    logic [2:0]         req0_op;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [2:0]         req1_op;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               res_valid;
    logic               res_ready;
    logic [2*WIDTH-1:0] res_data;
    logic               res_src;
    logic               res_err;
    logic               busy;
    logic [CNT_W-1:0]   op_count;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_src, res_err, busy, op_count
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_src, res_err, busy, op_count
    );
endinterface

// File: rtl/vector_op_arbiter.sv
// Round-robin arbiter sharing one vector logic unit between two requesters,
// with a registered compute stage and a result held until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the granted port
// EXEC  | operands latched; result computed and registered
// HOLD  | result valid; waiting for res_ready
module vector_op_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    vector_op_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q;
    logic                 last_grant_q;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 src_q;
    logic                 res_valid_q;
    logic [2*WIDTH-1:0]   res_data_q;
    logic                 res_src_q;
    logic                 res_err_q;
    logic [CNT_W-1:0]     op_count_q;

    logic                 grant_any;
    logic                 grant_sel;
    logic [2*WIDTH-1:0]   calc_data;
    logic                 calc_err;

    // Ready is withheld during reset so nothing is accepted on the reset edge.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_sel = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
                grant_sel = 1'b0;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_any && !grant_sel;
    assign bus.req1_ready = grant_any && grant_sel;

    always_comb begin
        calc_data = '0;
        calc_err  = 1'b0;
        case (op_q)
            3'd0: calc_data = {{WIDTH{1'b0}}, a_q & b_q};
            3'd1: calc_data = {{WIDTH{1'b0}}, a_q | b_q};
            3'd2: calc_data = {{(2*WIDTH-1){1'b0}}, (|a_q) && (|b_q)};
            3'd3: calc_data = {{(2*WIDTH-1){1'b0}}, |a_q};
            3'd4: calc_data = {{(2*WIDTH-1){1'b0}}, |b_q};
            3'd5: calc_data = {~a_q, ~b_q};
            default: calc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            src_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_src_q    <= 1'b0;
            res_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        op_q         <= grant_sel ? bus.req1_op : bus.req0_op;
                        a_q          <= grant_sel ? bus.req1_a  : bus.req0_a;
                        b_q          <= grant_sel ? bus.req1_b  : bus.req0_b;
                        src_q        <= grant_sel;
                        last_grant_q <= grant_sel;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= calc_data;
                    res_err_q   <= calc_err;
                    res_src_q   <= src_q;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_src   = res_src_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_vector_op_arbiter.sv
// Bench for vector_op_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of grants, results, latency and the op counter.
module tb_vector_op_arbiter;
    localparam int W  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_op_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus();
    vector_op_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int src;
        int data;
        int err;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   m_last, m_pending, m_delay, m_count;
    int   rr_mode, oneshot, rnd_req;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t ref_op(int src, int op, int a, int b);
        exp_t r;
        r.src = src;
        r.data = 0;
        r.err = 0;
        case (op)
            0: for (int i = 0; i < W; i++)
                   if ((a >> i) % 2 == 1 && (b >> i) % 2 == 1) r.data += (1 << i);
            1: for (int i = 0; i < W; i++)
                   if ((a >> i) % 2 == 1 || (b >> i) % 2 == 1) r.data += (1 << i);
            2: r.data = (a != 0 && b != 0) ? 1 : 0;
            3: r.data = (a != 0) ? 1 : 0;
            4: r.data = (b != 0) ? 1 : 0;
            5: r.data = (1 << (2 * W)) - 1 - (a * (1 << W) + b);
            default: r.err = 1;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_pending = 0;
        m_delay = 0;
        m_count = 0;
        exp_q.delete();
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_src", bus.res_src, 0);
        chk("rst_res_err", bus.res_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_op_count", bus.op_count, 0);
        rst_n = 1'b1;
    endtask

    task automatic run(int n);
        for (int c = 0; c < n; c++) begin
            int   g;
            int   drop;
            exp_t e;
            if (rnd_req != 0) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_op    = 3'($urandom_range(0, 7));
                bus.req0_a     = 4'($urandom_range(0, 15));
                bus.req0_b     = 4'($urandom_range(0, 15));
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_op    = 3'($urandom_range(0, 7));
                bus.req1_a     = 4'($urandom_range(0, 15));
                bus.req1_b     = 4'($urandom_range(0, 15));
            end
            case (rr_mode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = 1'b0;
                default: bus.res_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            g = -1;
            if (m_pending == 0) begin
                if (bus.req0_valid && bus.req1_valid) g = (m_last == 1) ? 0 : 1;
                else if (bus.req0_valid) g = 0;
                else if (bus.req1_valid) g = 1;
            end
            chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
            chk("ready0", bus.req0_ready, (g == 0) ? 1 : 0);
            chk("ready1", bus.req1_ready, (g == 1) ? 1 : 0);
            chk("busy", bus.busy, (m_pending != 0) ? 1 : 0);
            chk("res_valid", bus.res_valid, (m_pending != 0 && m_delay == 0) ? 1 : 0);
            chk("op_count", bus.op_count, m_count);
            if (m_pending != 0 && m_delay == 0 && exp_q.size() > 0) begin
                chk("res_data", bus.res_data, exp_q[0].data);
                chk("res_src", bus.res_src, exp_q[0].src);
                chk("res_err", bus.res_err, exp_q[0].err);
                if (bus.res_ready) begin
                    void'(exp_q.pop_front());
                    m_pending = 0;
                    m_count = (m_count + 1) % (1 << CW);
                end
            end
            drop = -1;
            if (g >= 0) begin
                if (g == 0) e = ref_op(0, bus.req0_op, bus.req0_a, bus.req0_b);
                else        e = ref_op(1, bus.req1_op, bus.req1_a, bus.req1_b);
                exp_q.push_back(e);
                m_pending = 1;
                m_delay = 2;
                m_last = g;
                if (oneshot != 0) drop = g;
            end
            if (m_delay > 0) m_delay--;
            @(posedge clk);
            #1;
            if (drop == 0) bus.req0_valid = 1'b0;
            if (drop == 1) bus.req1_valid = 1'b0;
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready = 1'b0;
        rr_mode = 0; oneshot = 1; rnd_req = 0;
        model_reset();
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        do_reset();

        // Single request: 1100 & 1010 = 08
        bus.req0_op = 3'd0; bus.req0_a = 4'b1100; bus.req0_b = 4'b1010;
        run(4);
        chk("single_count", bus.op_count, 1);

        // Continuous contention from a fresh reset
        bus.req0_valid = 1'b1; bus.req0_op = 3'd5; bus.req0_a = 4'h3; bus.req0_b = 4'h5;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 4'h3; bus.req1_b = 4'h5;
        do_reset();
        oneshot = 0;
        run(12);
        chk("contention_count", bus.op_count, 4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        oneshot = 1;
        run(3);

        // Logical and reduction ops on port 1
        bus.req1_valid = 1'b1; bus.req1_op = 3'd2; bus.req1_a = 4'h0; bus.req1_b = 4'hF;
        run(4);
        bus.req1_valid = 1'b1; bus.req1_op = 3'd3; bus.req1_a = 4'h4; bus.req1_b = 4'h0;
        run(4);
        bus.req1_valid = 1'b1; bus.req1_op = 3'd4; bus.req1_a = 4'hF; bus.req1_b = 4'h0;
        run(4);

        // Backpressure with the other port waiting
        bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 4'h9; bus.req0_b = 4'h6;
        rr_mode = 1;
        run(1);
        bus.req1_valid = 1'b1; bus.req1_op = 3'd0; bus.req1_a = 4'hF; bus.req1_b = 4'h3;
        run(12);
        rr_mode = 0;
        run(5);

        // Illegal opcode, then a legal op clears the error flag
        bus.req0_valid = 1'b1; bus.req0_op = 3'd7; bus.req0_a = 4'hF; bus.req0_b = 4'hF;
        run(4);
        bus.req0_valid = 1'b1; bus.req0_op = 3'd6; bus.req0_a = 4'h1; bus.req0_b = 4'h2;
        run(4);
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 4'hF; bus.req0_b = 4'h5;
        run(4);

        // Reset during EXEC, with port 1 left pending
        bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 4'h2; bus.req0_b = 4'h4;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd3; bus.req1_a = 4'h8; bus.req1_b = 4'h0;
        run(1);
        chk("mid_exec_busy", bus.busy, 1);
        do_reset();
        run(4);

        // Reset during HOLD
        bus.req0_valid = 1'b1; bus.req0_op = 3'd5; bus.req0_a = 4'hA; bus.req0_b = 4'h1;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd0; bus.req1_a = 4'h6; bus.req1_b = 4'h3;
        rr_mode = 1;
        run(2);
        chk("mid_hold_valid", bus.res_valid, 1);
        do_reset();
        rr_mode = 0;
        run(6);

        // Random traffic with random backpressure
        rnd_req = 1;
        rr_mode = 2;
        run(1500);

        // Saturated traffic long enough to wrap the op counter
        rnd_req = 0;
        oneshot = 0;
        rr_mode = 0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        run(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
